// File: rtl/csr_trans_regs_if.sv
// CSR access bundle between the EX stage and the translation CSR block.
// Reads return one cycle later; writes carry a bit mask for csrxchg.
interface csr_trans_regs_if;
    logic        rd_en;
    logic [13:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] wr_mask;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_mask,
        input  rd_data, rd_valid
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_mask,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/csr_trans_regs.sv
// CRMD/PRMD/DMW0/DMW1 with exception-entry and ertn hardware updates.
// Feeds the translation controls straight out of the registers.
module csr_trans_regs #(
    parameter logic [13:0] CSR_CRMD = 14'h000,
    parameter logic [13:0] CSR_PRMD = 14'h001,
    parameter logic [13:0] CSR_DMW0 = 14'h180,
    parameter logic [13:0] CSR_DMW1 = 14'h181
) (
    input  logic                   clk,
    input  logic                   rst,
    csr_trans_regs_if.slave        bus,
    input  logic                   excp_en,
    input  logic                   excp_tlbr,
    input  logic                   ertn_en,
    output logic                   csr_da,
    output logic                   csr_pg,
    output logic [1:0]             csr_plv,
    output logic [31:0]            csr_dmw0,
    output logic [31:0]            csr_dmw1
);
    localparam logic [31:0] CRMD_M = 32'h0000_01FF;
    localparam logic [31:0] PRMD_M = 32'h0000_0007;
    localparam logic [31:0] DMW_M  = 32'hEE00_0039;

    logic [31:0] crmd_q, crmd_d;
    logic [31:0] prmd_q, prmd_d;
    logic [31:0] dmw0_q, dmw0_d;
    logic [31:0] dmw1_q, dmw1_d;
    logic        tlbr_q, tlbr_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [31:0] mask,
        input logic [31:0] fmask
    );
        return ((old & ~mask) | (data & mask)) & fmask;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crmd_q     <= 32'h0000_0008;
            prmd_q     <= '0;
            dmw0_q     <= '0;
            dmw1_q     <= '0;
            tlbr_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            crmd_q     <= crmd_d;
            prmd_q     <= prmd_d;
            dmw0_q     <= dmw0_d;
            dmw1_q     <= dmw1_d;
            tlbr_q     <= tlbr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= bus.rd_en;
        end
    end

    // Exception beats ertn beats software write; losers are dropped.
    always_comb begin
        crmd_d = crmd_q;
        prmd_d = prmd_q;
        dmw0_d = dmw0_q;
        dmw1_d = dmw1_q;
        tlbr_d = tlbr_q;
        if (excp_en) begin
            prmd_d      = {29'd0, crmd_q[2:0]};
            crmd_d[2:0] = 3'd0;
            if (excp_tlbr) begin
                crmd_d[3] = 1'b1;
                crmd_d[4] = 1'b0;
                tlbr_d    = 1'b1;
            end
        end else if (ertn_en) begin
            crmd_d[2:0] = prmd_q[2:0];
            if (tlbr_q) begin
                crmd_d[3] = 1'b0;
                crmd_d[4] = 1'b1;
                tlbr_d    = 1'b0;
            end
        end else if (bus.wr_en) begin
            case (bus.wr_addr)
                CSR_CRMD: crmd_d = merge(crmd_q, bus.wr_data, bus.wr_mask, CRMD_M);
                CSR_PRMD: prmd_d = merge(prmd_q, bus.wr_data, bus.wr_mask, PRMD_M);
                CSR_DMW0: dmw0_d = merge(dmw0_q, bus.wr_data, bus.wr_mask, DMW_M);
                CSR_DMW1: dmw1_d = merge(dmw1_q, bus.wr_data, bus.wr_mask, DMW_M);
                default:  ;
            endcase
        end
    end

    // Read samples the pre-update registers, so same-cycle writes are not seen.
    always_comb begin
        rd_data_d = rd_data_q;
        if (bus.rd_en) begin
            case (bus.rd_addr)
                CSR_CRMD: rd_data_d = crmd_q;
                CSR_PRMD: rd_data_d = prmd_q;
                CSR_DMW0: rd_data_d = dmw0_q;
                CSR_DMW1: rd_data_d = dmw1_q;
                default:  rd_data_d = '0;
            endcase
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign csr_plv      = crmd_q[1:0];
    assign csr_da       = crmd_q[3];
    assign csr_pg       = crmd_q[4];
    assign csr_dmw0     = dmw0_q;
    assign csr_dmw1     = dmw1_q;
endmodule

// File: tb/tb_csr_trans_regs.sv
// Scoreboard bench for csr_trans_regs: directed plan then random traffic
// against a field-level model of the four CSRs.
module tb_csr_trans_regs;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        excp_en = 1'b0;
    logic        excp_tlbr = 1'b0;
    logic        ertn_en = 1'b0;
    logic        csr_da, csr_pg;
    logic [1:0]  csr_plv;
    logic [31:0] csr_dmw0, csr_dmw1;

    csr_trans_regs_if bus();

    csr_trans_regs dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .excp_en   (excp_en),
        .excp_tlbr (excp_tlbr),
        .ertn_en   (ertn_en),
        .csr_da    (csr_da),
        .csr_pg    (csr_pg),
        .csr_plv   (csr_plv),
        .csr_dmw0  (csr_dmw0),
        .csr_dmw1  (csr_dmw1)
    );

    always #5 clk = ~clk;

    // Reference model state: the architectural view after the next edge.
    logic [31:0] m_crmd, m_prmd;
    logic [31:0] m_dmw [2];
    bit          m_tlbr;
    logic [31:0] exp_q [$];

    int nvec = 0;
    int nerr = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    function automatic void model_reset();
        m_crmd = 32'd8;
        m_prmd = 32'd0;
        m_dmw[0] = 32'd0;
        m_dmw[1] = 32'd0;
        m_tlbr = 1'b0;
        exp_q.delete();
    endfunction

    function automatic logic [31:0] model_rd(input logic [13:0] a);
        case (a)
            14'h000: return m_crmd;
            14'h001: return m_prmd;
            14'h180: return m_dmw[0];
            14'h181: return m_dmw[1];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] upd(input logic [31:0] old, d, m, f);
        return ((old & ~m) | (d & m)) & f;
    endfunction

    function automatic void model_step(input bit we, input logic [13:0] wa,
                                       input logic [31:0] wd, wm,
                                       input bit ex, tl, er);
        int plv_ie;
        if (ex) begin
            plv_ie = int'(m_crmd % 8);
            m_prmd = 32'(plv_ie);
            m_crmd = m_crmd - 32'(plv_ie);
            if (tl) begin
                m_crmd = m_crmd | 32'd8;
                m_crmd = m_crmd & ~32'd16;
                m_tlbr = 1'b1;
            end
        end else if (er) begin
            m_crmd = (m_crmd & ~32'd7) | (m_prmd % 8);
            if (m_tlbr) begin
                m_crmd = (m_crmd & ~32'd8) | 32'd16;
                m_tlbr = 1'b0;
            end
        end else if (we) begin
            case (wa)
                14'h000: m_crmd = upd(m_crmd, wd, wm, 32'h1FF);
                14'h001: m_prmd = upd(m_prmd, wd, wm, 32'h7);
                14'h180: m_dmw[0] = upd(m_dmw[0], wd, wm, 32'hEE000039);
                14'h181: m_dmw[1] = upd(m_dmw[1], wd, wm, 32'hEE000039);
                default: ;
            endcase
        end
    endfunction

    task automatic step(input bit re, input logic [13:0] ra,
                        input bit we, input logic [13:0] wa,
                        input logic [31:0] wd, wm,
                        input bit ex, tl, er);
        @(negedge clk);
        bus.rd_en = re;
        bus.rd_addr = ra;
        bus.wr_en = we;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.wr_mask = wm;
        excp_en = ex;
        excp_tlbr = tl;
        ertn_en = er;
        if (re) exp_q.push_back(model_rd(ra));
        model_step(we, wa, wd, wm, ex, tl, er);
        @(posedge clk);
        #2;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        excp_en = 1'b0;
        excp_tlbr = 1'b0;
        ertn_en = 1'b0;
    endtask

    task automatic rd(input logic [13:0] a);
        step(1'b1, a, 1'b0, 14'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d, m);
        step(1'b0, 14'h0, 1'b1, a, d, m, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: pops a read expectation whenever the DUT presents rd_valid.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (bus.rd_valid) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL rd_valid: got 1 expected 0 (no read pending)");
                end else begin
                    chk("rd_data", bus.rd_data, exp_q.pop_front());
                end
            end
            chk("csr_ctl", {27'd0, csr_da, csr_pg, csr_plv},
                {27'd0, m_crmd[3], m_crmd[4], m_crmd[1:0]});
            chk("csr_dmw0", csr_dmw0, m_dmw[0]);
            chk("csr_dmw1", csr_dmw1, m_dmw[1]);
        end
    end

    initial begin
        logic [13:0] addrs [5];
        logic [13:0] a;
        bus.rd_en = 1'b0;
        bus.rd_addr = '0;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.wr_mask = '0;
        model_reset();
        #1;
        chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("rst_rd_data", bus.rd_data, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        rd(14'h000);
        chk("reset_da_pg_plv", {28'd0, csr_da, csr_pg, csr_plv}, 32'h8);
        step(1'b0, 14'h0, 1'b0, 14'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        wr(14'h180, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("dmw0_all_ones", csr_dmw0, 32'hEE00_0039);
        rd(14'h180);

        wr(14'h000, 32'h13, 32'h1B);
        chk("xchg_crmd", {28'd0, csr_da, csr_pg, csr_plv}, 32'h7);
        rd(14'h000);

        wr(14'h000, 32'h17, 32'hFFFF_FFFF);
        step(1'b0, 14'h0, 1'b0, 14'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        rd(14'h001);
        rd(14'h000);
        chk("tlbr_entry_da", {31'd0, csr_da}, 32'd1);
        step(1'b0, 14'h0, 1'b0, 14'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("ertn_pg", {31'd0, csr_pg}, 32'd1);
        rd(14'h000);

        // Exception beats a same-cycle DMW1 write.
        wr(14'h181, 32'h2000_0011, 32'hFFFF_FFFF);
        step(1'b0, 14'h0, 1'b1, 14'h181, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             1'b1, 1'b0, 1'b0);
        chk("excp_drops_wr", csr_dmw1, 32'h2000_0011);
        step(1'b1, 14'h181, 1'b1, 14'h181, 32'hC000_0008, 32'hFFFF_FFFF,
             1'b0, 1'b0, 1'b0);
        rd(14'h181);

        // Async reset while a TLB-refill return is still armed.
        step(1'b0, 14'h0, 1'b0, 14'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        wr(14'h000, 32'h17, 32'hFFFF_FFFF);
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_ctl", {28'd0, csr_da, csr_pg, csr_plv}, 32'h8);
        chk("async_rst_dmw1", csr_dmw1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 14'h0, 1'b0, 14'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("ertn_after_rst", {28'd0, csr_da, csr_pg, csr_plv}, 32'h8);
        rd(14'h000);

        addrs[0] = 14'h000;
        addrs[1] = 14'h001;
        addrs[2] = 14'h180;
        addrs[3] = 14'h181;
        addrs[4] = 14'h002;
        for (int i = 0; i < 400; i++) begin
            a = addrs[$urandom_range(0, 4)];
            if ($urandom_range(0, 9) == 0) a = 14'($urandom);
            step($urandom_range(0, 1) == 1, addrs[$urandom_range(0, 4)],
                 $urandom_range(0, 2) != 0, a, $urandom,
                 ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0);
        end

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL rd_pending: got %0d outstanding expected 0",
                     exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
